// File: rtl/fsmctl_pkg.sv
// Shared types and default sizes for the table-driven FSM controller.
// The state code and output field are both 3 bits wide by default, so one table
// word holds {next_state, out} and one address is {state, a}.
package fsmctl_pkg;

  // Controller modes: loading/idle, free-running, and paused for single-stepping.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } ctrl_t;

  localparam int FSMCTL_SW = 3;
  localparam int FSMCTL_OW = 3;
  localparam int FSMCTL_AW = FSMCTL_SW + 1;
  localparam int FSMCTL_DW = FSMCTL_SW + FSMCTL_OW;

  localparam logic [FSMCTL_SW-1:0] RST_STATE_DEFAULT = 3'd2;

endpackage

// File: rtl/fsmctl_table.sv
// Transition table storage: one synchronous write port, one asynchronous read port.
// Contents are never reset; entries that were not loaded read back as X in simulation.
module fsmctl_table
  import fsmctl_pkg::*;
#(
  parameter int AW = FSMCTL_AW,
  parameter int DW = FSMCTL_DW
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];

  // Accepted writes land on the clock edge; the read port sees them from the next cycle.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fsm_table_ctrl.sv
// Programmable table-driven state machine controller.
// The machine state indexes the table together with input bit 'a'; each entry gives the
// next state and the Mealy output. The controller loads the table in IDLE/PAUSE, runs one
// transition per clock in RUN, and single-steps in PAUSE.
// Optional build macro FSMCTL_CYCLE_CNT_EN adds an 8-bit wrapping advance counter (adv_cnt).
module fsm_table_ctrl
  import fsmctl_pkg::*;
#(
  parameter int             SW        = FSMCTL_SW,
  parameter int             OW        = FSMCTL_OW,
  parameter int             AW        = SW + 1,
  parameter int             DW        = SW + OW,
  parameter logic [SW-1:0]  RST_STATE = SW'(RST_STATE_DEFAULT)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          start,
  input  logic          stop,
  input  logic          step,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          a,
  output logic [SW-1:0] state_o,
  output logic [OW-1:0] saida,
  output logic          run_o
`ifdef FSMCTL_CYCLE_CNT_EN
  ,
  output logic [7:0]    adv_cnt
`endif
);

  ctrl_t         ctrl_q;
  ctrl_t         ctrl_d;
  logic [SW-1:0] state_q;
  logic          run_q;
  logic          wrRdy_q;
  logic          advance;
  logic          tblWe;
  logic [DW-1:0] tblData;
`ifdef FSMCTL_CYCLE_CNT_EN
  logic [7:0]    advCnt_q;
`endif

  // A clear on the same edge as a write drops the write, so the table is never touched mid-abort.
  assign tblWe = wr_valid & wrRdy_q & ~clear;

  fsmctl_table #(
    .AW (AW),
    .DW (DW)
  ) u_table (
    .clk     (clk),
    .we_i    (tblWe),
    .waddr_i (wr_addr),
    .wdata_i (wr_data),
    .raddr_i ({state_q, a}),
    .rdata_o (tblData)
  );

  // Command decode with priority clear > stop > start > step; 'advance' marks a table transition.
  always_comb begin
    ctrl_d  = ctrl_q;
    advance = 1'b0;
    if (clear) begin
      ctrl_d = IDLE;
    end else begin
      case (ctrl_q)
        IDLE: begin
          if (!stop && start) ctrl_d = RUN;
        end
        RUN: begin
          if (stop) ctrl_d = PAUSE;
          else      advance = 1'b1;
        end
        PAUSE: begin
          if (!stop) begin
            if (start)     ctrl_d = RUN;
            else if (step) advance = 1'b1;
          end
        end
        default: ctrl_d = IDLE;
      endcase
    end
  end

  // Controller mode, machine state, registered status outputs and the optional advance counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q   <= IDLE;
      state_q  <= RST_STATE;
      run_q    <= 1'b0;
      wrRdy_q  <= 1'b1;
`ifdef FSMCTL_CYCLE_CNT_EN
      advCnt_q <= 8'd0;
`endif
    end else begin
      ctrl_q  <= ctrl_d;
      run_q   <= (ctrl_d == RUN);
      wrRdy_q <= (ctrl_d != RUN);
      if (clear)        state_q <= RST_STATE;
      else if (advance) state_q <= tblData[DW-1:OW];
`ifdef FSMCTL_CYCLE_CNT_EN
      if (clear)        advCnt_q <= 8'd0;
      else if (advance) advCnt_q <= advCnt_q + 8'd1;
`endif
    end
  end

  assign state_o  = state_q;
  assign saida    = tblData[OW-1:0];
  assign run_o    = run_q;
  assign wr_ready = wrRdy_q;
`ifdef FSMCTL_CYCLE_CNT_EN
  assign adv_cnt  = advCnt_q;
`endif

endmodule

// File: tb/tb_fsm_table_ctrl.sv
// Directed self-checking bench for fsm_table_ctrl.
// Loads a small transition table whose output field equals the current state code, then
// walks through run, pause/step, write gating, command priority and async reset.
// With FSMCTL_CYCLE_CNT_EN defined it also checks the advance counter and its wrap.
module tb_fsm_table_ctrl;

  logic       clk;
  logic       reset;
  logic       clear;
  logic       start;
  logic       stop;
  logic       step;
  logic       wr_valid;
  logic       wr_ready;
  logic [3:0] wr_addr;
  logic [5:0] wr_data;
  logic       a;
  logic [2:0] state_o;
  logic [2:0] saida;
  logic       run_o;
`ifdef FSMCTL_CYCLE_CNT_EN
  logic [7:0] adv_cnt;
`endif

  int testCount = 0;
  int failCount = 0;

  logic [2:0] seqA0 [8] = '{3'd4, 3'd1, 3'd6, 3'd7, 3'd4, 3'd1, 3'd6, 3'd7};
  logic [2:0] seqA1 [6] = '{3'd4, 3'd6, 3'd7, 3'd2, 3'd4, 3'd6};

  fsm_table_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .start    (start),
    .stop     (stop),
    .step     (step),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .a        (a),
    .state_o  (state_o),
    .saida    (saida),
    .run_o    (run_o)
`ifdef FSMCTL_CYCLE_CNT_EN
    ,
    .adv_cnt  (adv_cnt)
`endif
  );

  // Free-running 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds the given command inputs across one rising edge, then returns them to idle.
  task automatic applyStimulus(input logic st, input logic sp, input logic stp, input logic clr);
    start = st;
    stop  = sp;
    step  = stp;
    clear = clr;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    step  = 1'b0;
    clear = 1'b0;
  endtask

  task automatic writeEntry(input logic [3:0] addr, input logic [5:0] data);
    wr_valid = 1'b1;
    wr_addr  = addr;
    wr_data  = data;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    testCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    reset    = 1'b0;
    clear    = 1'b0;
    start    = 1'b0;
    stop     = 1'b0;
    step     = 1'b0;
    wr_valid = 1'b0;
    wr_addr  = 4'd0;
    wr_data  = 6'd0;
    a        = 1'b0;

    #12;
    checkOutput("rstState", 8'(state_o), 8'd2);
    checkOutput("rstRun", 8'(run_o), 8'd0);
    checkOutput("rstWrReady", 8'(wr_ready), 8'd1);
`ifdef FSMCTL_CYCLE_CNT_EN
    checkOutput("rstCnt", adv_cnt, 8'd0);
`endif
    reset = 1'b1;
    tick();

    // Table load: address {state,a}, data {next,out} with out = state.
    writeEntry(4'd4,  {3'd4, 3'd2});
    writeEntry(4'd5,  {3'd4, 3'd2});
    writeEntry(4'd8,  {3'd1, 3'd4});
    writeEntry(4'd9,  {3'd6, 3'd4});
    writeEntry(4'd2,  {3'd6, 3'd1});
    writeEntry(4'd3,  {3'd6, 3'd1});
    writeEntry(4'd12, {3'd7, 3'd6});
    writeEntry(4'd13, {3'd7, 3'd6});
    writeEntry(4'd14, {3'd4, 3'd7});
    writeEntry(4'd15, {3'd2, 3'd7});

    // A write coinciding with clear is dropped.
    wr_valid = 1'b1;
    wr_addr  = 4'd4;
    wr_data  = {3'd6, 3'd3};
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    wr_valid = 1'b0;
    a = 1'b0;
    #1;
    checkOutput("clrDropsWrite", 8'(saida), 8'd2);

    // T1: run with a=0.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("t1StartNoAdv", 8'(state_o), 8'd2);
    checkOutput("t1RunOn", 8'(run_o), 8'd1);
    checkOutput("t1WrReadyLow", 8'(wr_ready), 8'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      checkOutput("t1State", 8'(state_o), 8'(seqA0[i]));
      checkOutput("t1Saida", 8'(saida), 8'(seqA0[i]));
    end
`ifdef FSMCTL_CYCLE_CNT_EN
    checkOutput("t1Cnt", adv_cnt, 8'd8);
`endif
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("clrState", 8'(state_o), 8'd2);
    checkOutput("clrRun", 8'(run_o), 8'd0);

    // T2: run with a=1.
    a = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("t2RunOn", 8'(run_o), 8'd1);
    checkOutput("t2StartNoAdv", 8'(state_o), 8'd2);
    for (int i = 0; i < 6; i++) begin
      tick();
      checkOutput("t2State", 8'(state_o), 8'(seqA1[i]));
      checkOutput("t2Saida", 8'(saida), 8'(seqA1[i]));
    end

    // T3: stop at state 6, then single-step with a=0.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("t3StopHold", 8'(state_o), 8'd6);
    checkOutput("t3RunOff", 8'(run_o), 8'd0);
    checkOutput("t3WrReady", 8'(wr_ready), 8'd1);
    tick();
    checkOutput("t3PauseHold", 8'(state_o), 8'd6);
    a = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("t3Step1", 8'(state_o), 8'd7);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("t3Step2", 8'(state_o), 8'd4);
    checkOutput("t3StepRun", 8'(run_o), 8'd0);

    // T4: write during RUN is refused; write with start in IDLE is accepted.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("t4WrReadyRun", 8'(wr_ready), 8'd0);
    wr_valid = 1'b1;
    wr_addr  = 4'd8;
    wr_data  = {3'd7, 3'd5};
    tick();
    wr_valid = 1'b0;
    checkOutput("t4RunState", 8'(state_o), 8'd4);
    checkOutput("t4EntryKeptOut", 8'(saida), 8'd4);
    tick();
    checkOutput("t4EntryKeptNext", 8'(state_o), 8'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    wr_valid = 1'b1;
    wr_addr  = 4'd4;
    wr_data  = {3'd6, 3'd3};
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    wr_valid = 1'b0;
    checkOutput("t4WrStartRun", 8'(run_o), 8'd1);
    checkOutput("t4NewOut", 8'(saida), 8'd3);
    tick();
    checkOutput("t4NewNext", 8'(state_o), 8'd6);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    writeEntry(4'd4, {3'd4, 3'd2});
    checkOutput("t4Restored", 8'(saida), 8'd2);

    // T5: command priority.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("t5StartStopRun", 8'(run_o), 8'd0);
    checkOutput("t5StartStopSt", 8'(state_o), 8'd2);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("t5StepIdle", 8'(state_o), 8'd2);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("t5PauseState", 8'(state_o), 8'd4);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("t5ClrStartRun", 8'(run_o), 8'd0);
    checkOutput("t5ClrStartSt", 8'(state_o), 8'd2);
    checkOutput("t5ClrWrReady", 8'(wr_ready), 8'd1);

    // T6: asynchronous reset in the middle of RUN.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("t6PreReset", 8'(state_o), 8'd1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("t6AsyncState", 8'(state_o), 8'd2);
    checkOutput("t6AsyncRun", 8'(run_o), 8'd0);
    checkOutput("t6AsyncWrRdy", 8'(wr_ready), 8'd1);
`ifdef FSMCTL_CYCLE_CNT_EN
    checkOutput("t6AsyncCnt", adv_cnt, 8'd0);
`endif
    reset = 1'b1;
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("t6TableKept", 8'(state_o), 8'd4);

`ifdef FSMCTL_CYCLE_CNT_EN
    // Counter: clear zeroes it, 256 advances wrap it back to zero.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("cntClear", adv_cnt, 8'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (256) tick();
    checkOutput("cntWrap", adv_cnt, 8'd0);
    tick();
    checkOutput("cntAfterWrap", adv_cnt, 8'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
